vec_decode_rf: RTL
==================

// Module: vec_decode_rf
// PURPOSE
//  Vector decode stage with integrated 32-entry vector register file, RAW/WAW
//  scoreboard, write-back bypass and valid/ready output register. Sits between
//  fetch and the vector execute unit and accepts one vector instruction per cycle.
//  Successor to the fixed-width decode stage. Adds back-pressure, hazard stalls,
//  same-cycle write-back forwarding and full RVV funct3 source classification.
// PARAMETERS
//  VLEN   256  vector register width in bits
//  IMM_W  11   width of vec_imm; OPIVI simm5 is sign-extended to IMM_W
//  SB_EN  1    1 = scoreboard hazard stalls enabled; 0 = never stall on hazards
// PORTS
//  clk                 in   1     clock; all state updates on posedge
//  reset               in   1     synchronous, active-high
//  in_valid            in   1     instruction is valid
//  in_ready            out  1     stage can accept the instruction this cycle
//  instruction         in   32    RVV instruction word
//  wb_valid            in   1     vector write-back strobe
//  wb_rd               in   5     write-back destination register
//  wb_data             in   VLEN  write-back data
//  out_valid           out  1     decoded bundle valid
//  out_ready           in   1     execute unit accepts the bundle
//  vec_rd              out  5     destination (vd)
//  vec_rs1_out         out  VLEN  vreg[ins[19:15]]; for stores, vreg[ins[11:7]] (vs3)
//  vec_rs2_out         out  VLEN  vreg[ins[24:20]]
//  vec_imm             out  IMM_W sign-extended ins[19:15]
//  vec_src_d           out  2     0 = vector-vector, 1 = scalar (rs1), 2 = immediate
//  vec_regwrite_d      out  1     bundle writes vd
//  vec_load_d          out  1     unit-stride/strided vector load
//  vec_store_d         out  1     vector store
//  vec_illegal_d       out  1     unsupported encoding (bundle has no side effects)
// BEHAVIOUR
//  Reset (sync)
//   - All 32 vregs, the scoreboard and every output register are cleared to 0.
//   - in_ready is 0 during the reset cycle.
//   - Reset mid-stall drops the held bundle and clears all pending bits.
//  Decode (combinational, on instruction)
//   - OP_ARITH 1010111, by funct3:
//       000/001/010 -> src 0, sources vs1 and vs2
//       100/101/110 -> src 1, source vs2
//       011         -> src 2, source vs2
//       111         -> illegal
//     Legal arith ops set regwrite=1.
//   - OP_LOAD 0000111: load=1, regwrite=1, no vector sources.
//   - OP_STORE 0100111: store=1, regwrite=0, vector source vs3=ins[11:7].
//   - Any other opcode: illegal=1, regwrite=0, no sources, no hazard check.
//  Hazards
//   - pend[31:0] tracks outstanding writes. clr = wb_valid ? onehot(wb_rd) : 0.
//   - eff = pend & ~clr.
//   - hazard = SB_EN & (any used source set in eff | (regwrite & eff[vd])).
//   - in_ready = ~reset & ~hazard & (~out_valid | out_ready).
//   - acc = in_valid & in_ready.
//  Output register
//   - On acc: all outputs load the decoded values and out_valid <= 1.
//   - Else if out_ready: out_valid <= 0.
//   - Else: everything holds, bit-stable, through the stall.
//   - Latency: instruction to out_valid is 1 cycle.
//   - Throughput: 1 per cycle when there is no hazard and out_ready=1.
//  Register file
//   - On wb_valid, at posedge: vreg[wb_rd] <= wb_data. All 32 regs are writable (v0 = mask).
//   - Bypass: if wb_valid and wb_rd equals a read index on acc, the read value is
//     wb_data, not the stale array value.
//  Scoreboard update
//   - pend <= eff | (acc & regwrite ? onehot(vd) : 0). Set wins over clear.
//   - The set happens at acceptance, not when the bundle leaves.
//   - Write-back to a non-pending reg is legal; it only updates the array.
// TESTING
//  1. Reset, then OPIVV ins: vd=3, vs1=1, vs2=2, with v1=5, v2=7 preloaded via wb
//     -> next cycle out_valid=1, rs1_out=5, rs2_out=7, src=0, regwrite=1, pend[3]=1.
//  2. Back-to-back: vadd vd=3, then vadd vs1=3 with no wb -> in_ready=0 on the 2nd instr.
//     Assert wb_valid, wb_rd=3, wb_data=0xAA -> accepted that same cycle, rs1_out=0xAA (bypass).
//  3. Hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and all outputs stable.
//     Release -> next bundle accepted in that cycle.
//  4. OPIVI with ins[19:15]=5'b11110, IMM_W=11 -> vec_imm=11'h7FE, src=2.
//     OPIVX -> src=1. funct3=111 -> illegal=1, regwrite=0, pend unchanged.
//  5. Store with vs3=4 pending -> stalls. wb clears pend[4] -> store accepted,
//     rs1_out=wb_data, regwrite=0.
//  6. Issue a load to vd=6 (pend[6]=1), then reset mid-stall -> out_valid=0, pend=0,
//     vreg[6]=0. With SB_EN=0, the case-2 sequence never deasserts in_ready.

Source files
------------

// File: rtl/vec_decode_rf.sv
// vec_decode_rf: vector decode stage with an integrated 32 x VLEN register file,
// a RAW/WAW pending-write scoreboard, write-back bypass and a valid/ready output register.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   instruction handshake from fetch
//   instruction         32-bit RVV instruction word
//   wb_valid/wb_rd/     vector write-back into the register file;
//   wb_data             also clears the matching pending bit
//   out_valid/out_ready decoded-bundle handshake to the execute unit
//   vec_*               registered decoded bundle (operands, immediate, control flags)
module vec_decode_rf #(
    parameter int unsigned VLEN  = 256,
    parameter int unsigned IMM_W = 11,
    parameter bit          SB_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [VLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       vec_rd,
    output logic [VLEN-1:0]  vec_rs1_out,
    output logic [VLEN-1:0]  vec_rs2_out,
    output logic [IMM_W-1:0] vec_imm,
    output logic [1:0]       vec_src_d,
    output logic             vec_regwrite_d,
    output logic             vec_load_d,
    output logic             vec_store_d,
    output logic             vec_illegal_d
);

    localparam logic [6:0] OpArith = 7'b1010111;
    localparam logic [6:0] OpLoad  = 7'b0000111;
    localparam logic [6:0] OpStore = 7'b0100111;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] idx_vd, idx_vs1, idx_vs2, idx_rs1;
    logic       unused_funct;

    assign opcode       = instruction[6:0];
    assign funct3       = instruction[14:12];
    assign idx_vd       = instruction[11:7];
    assign idx_vs1      = instruction[19:15];
    assign idx_vs2      = instruction[24:20];
    assign unused_funct = ^instruction[31:25];

    // Decoded control
    logic [1:0] dec_src;
    logic       dec_regwrite, dec_load, dec_store, dec_illegal;
    logic       use_vs1, use_vs2, use_vs3;

    always_comb begin
        dec_src      = 2'd0;
        dec_regwrite = 1'b0;
        dec_load     = 1'b0;
        dec_store    = 1'b0;
        dec_illegal  = 1'b0;
        use_vs1      = 1'b0;
        use_vs2      = 1'b0;
        use_vs3      = 1'b0;
        case (opcode)
            OpArith: begin
                case (funct3)
                    3'b000, 3'b001, 3'b010: begin
                        dec_src = 2'd0;
                        use_vs1 = 1'b1;
                        use_vs2 = 1'b1;
                    end
                    3'b100, 3'b101, 3'b110: begin
                        dec_src = 2'd1;
                        use_vs2 = 1'b1;
                    end
                    3'b011: begin
                        dec_src = 2'd2;
                        use_vs2 = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
                dec_regwrite = ~dec_illegal;
            end
            OpLoad: begin
                dec_load     = 1'b1;
                dec_regwrite = 1'b1;
            end
            OpStore: begin
                dec_store = 1'b1;
                use_vs3   = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Register file with write-back bypass on the read ports
    logic [VLEN-1:0] vreg_q [32];
    logic [VLEN-1:0] vreg_d [32];
    logic [VLEN-1:0] rs1_val, rs2_val;

    // Stores read their data register (vs3) through the rs1 port
    assign idx_rs1 = dec_store ? idx_vd : idx_vs1;
    assign rs1_val = (wb_valid && wb_rd == idx_rs1) ? wb_data : vreg_q[idx_rs1];
    assign rs2_val = (wb_valid && wb_rd == idx_vs2) ? wb_data : vreg_q[idx_vs2];

    always_comb begin
        vreg_d = vreg_q;
        if (wb_valid) begin
            vreg_d[wb_rd] = wb_data;
        end
    end

    // Scoreboard: a write-back this cycle already resolves its pending bit
    logic [31:0] pend_q, pend_d, clr_mask, eff, set_mask;
    logic        hazard, acc;
    logic        out_valid_q, out_valid_d;

    assign clr_mask = wb_valid ? (32'b1 << wb_rd) : 32'b0;
    assign eff      = pend_q & ~clr_mask;

    always_comb begin
        hazard = 1'b0;
        if (SB_EN) begin
            hazard = (use_vs1 && eff[idx_vs1]) || (use_vs2 && eff[idx_vs2]) ||
                     (use_vs3 && eff[idx_vd]) || (dec_regwrite && eff[idx_vd]);
        end
    end

    assign in_ready = ~reset & ~hazard & (~out_valid_q | out_ready);
    assign acc      = in_valid & in_ready;
    assign set_mask = (acc && dec_regwrite) ? (32'b1 << idx_vd) : 32'b0;
    assign pend_d   = eff | set_mask;

    // Output register
    logic [4:0]       rd_q, rd_d;
    logic [VLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic [1:0]       src_q, src_d;
    logic             rw_q, rw_d, ld_q, ld_d, st_q, st_d, ill_q, ill_d;

    always_comb begin
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        src_d       = src_q;
        rw_d        = rw_q;
        ld_d        = ld_q;
        st_d        = st_q;
        ill_d       = ill_q;
        if (acc) begin
            out_valid_d = 1'b1;
            rd_d        = idx_vd;
            rs1_d       = rs1_val;
            rs2_d       = rs2_val;
            imm_d       = {{(IMM_W - 5){instruction[19]}}, instruction[19:15]};
            src_d       = dec_src;
            rw_d        = dec_regwrite;
            ld_d        = dec_load;
            st_d        = dec_store;
            ill_d       = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vreg_q      <= '{default: '0};
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            src_q       <= '0;
            rw_q        <= 1'b0;
            ld_q        <= 1'b0;
            st_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            vreg_q      <= vreg_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            src_q       <= src_d;
            rw_q        <= rw_d;
            ld_q        <= ld_d;
            st_q        <= st_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign vec_rd         = rd_q;
    assign vec_rs1_out    = rs1_q;
    assign vec_rs2_out    = rs2_q;
    assign vec_imm        = imm_q;
    assign vec_src_d      = src_q;
    assign vec_regwrite_d = rw_q;
    assign vec_load_d     = ld_q;
    assign vec_store_d    = st_q;
    assign vec_illegal_d  = ill_q;

endmodule
